// File: rtl/bram_port_adapter.sv
// Adapter between a single-cycle request/grant core bus and a block RAM port.
// Every grant is answered exactly READ_LATENCY cycles later, in grant order;
// out-of-range requests never touch the BRAM and come back flagged as errors.
// Read, write and error counters saturate at 16'hFFFF.
module bram_port_adapter #(
    parameter int unsigned READ_LATENCY = 2,          // BRAM read latency, 1..4
    parameter int unsigned ADDR_WIDTH   = 16,         // BRAM byte-address width
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core side
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    // BRAM side
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic                  bram_en_o,
    output logic [3:0]            bram_we_o,
    output logic [31:0]           bram_wrdata_o,
    input  logic [31:0]           bram_rddata_i,
    output logic                  bram_rst_o,
    // statistics
    output logic [15:0]           rd_count_o,
    output logic [15:0]           wr_count_o,
    output logic [15:0]           err_count_o
);

    // Saturating +1 for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic w_gnt;
    logic w_in_range;
    logic w_bram_en;
    logic w_rvalid;
    logic w_resp_we;
    logic w_resp_err;
    logic w_unused_addr_lsb;

    // Response tracking pipeline: index 0 is loaded at the grant edge, the
    // last index lines up with the BRAM data arriving READ_LATENCY later.
    logic [READ_LATENCY-1:0] r_vld_p;
    logic [READ_LATENCY-1:0] r_we_p;
    logic [READ_LATENCY-1:0] r_err_p;

    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [15:0] r_err_count;

    // Byte lanes are chosen by be_i, so the word-offset bits carry no meaning.
    assign w_unused_addr_lsb = ^addr_i[1:0];

    // Grant is purely combinational: no back-pressure, one transaction per cycle.
    assign w_gnt      = req_i & rst_n;
    assign w_in_range = (addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign w_bram_en  = w_gnt & w_in_range;

    assign gnt_o         = w_gnt;
    assign bram_en_o     = w_bram_en;
    assign bram_addr_o   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign bram_we_o     = (w_bram_en && we_i) ? be_i : 4'b0000;
    assign bram_wrdata_o = wdata_i;
    assign bram_rst_o    = ~rst_n;

    // Shift {valid, we, err} of every grant towards the response slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p <= '0;
            r_we_p  <= '0;
            r_err_p <= '0;
        end else begin
            r_vld_p[0] <= w_gnt;
            r_we_p[0]  <= we_i;
            r_err_p[0] <= ~w_in_range;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
                r_we_p[i]  <= r_we_p[i-1];
                r_err_p[i] <= r_err_p[i-1];
            end
        end
    end

    // Response stage: BRAM data passes only for successful reads.
    assign w_rvalid   = r_vld_p[READ_LATENCY-1];
    assign w_resp_we  = r_we_p[READ_LATENCY-1];
    assign w_resp_err = r_err_p[READ_LATENCY-1];

    assign rvalid_o = w_rvalid;
    assign err_o    = w_rvalid & w_resp_err;
    assign rdata_o  = (w_rvalid && !w_resp_we && !w_resp_err) ? bram_rddata_i : 32'h0;

    // Statistics: reads/writes counted at grant, errors at their response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count  <= 16'h0;
            r_wr_count  <= 16'h0;
            r_err_count <= 16'h0;
        end else begin
            if (w_bram_en && !we_i) begin
                r_rd_count <= sat_inc(r_rd_count);
            end
            if (w_bram_en && we_i) begin
                r_wr_count <= sat_inc(r_wr_count);
            end
            if (err_o) begin
                r_err_count <= sat_inc(r_err_count);
            end
        end
    end

    assign rd_count_o  = r_rd_count;
    assign wr_count_o  = r_wr_count;
    assign err_count_o = r_err_count;

endmodule

// File: tb/tb_bram_port_adapter.sv
// Bench for bram_port_adapter: a behavioural BRAM (read-first, 2-cycle
// latency), a transaction-level reference model with a byte-addressed shadow
// memory, a per-cycle compare process and directed literal expectations.
module tb_bram_port_adapter;

    localparam int          L    = 2;
    localparam int          AW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          req_i         = 1'b0;
    logic          gnt_o;
    logic [31:0]   addr_i        = 32'h0;
    logic          we_i          = 1'b0;
    logic [3:0]    be_i          = 4'h0;
    logic [31:0]   wdata_i       = 32'h0;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic [AW-1:0] bram_addr_o;
    logic          bram_en_o;
    logic [3:0]    bram_we_o;
    logic [31:0]   bram_wrdata_o;
    logic [31:0]   bram_rddata_i;
    logic          bram_rst_o;
    logic [15:0]   rd_count_o;
    logic [15:0]   wr_count_o;
    logic [15:0]   err_count_o;

    bram_port_adapter #(
        .READ_LATENCY(L),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bram_addr_o  (bram_addr_o),
        .bram_en_o    (bram_en_o),
        .bram_we_o    (bram_we_o),
        .bram_wrdata_o(bram_wrdata_o),
        .bram_rddata_i(bram_rddata_i),
        .bram_rst_o   (bram_rst_o),
        .rd_count_o   (rd_count_o),
        .wr_count_o   (wr_count_o),
        .err_count_o  (err_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Initial memory image: word 4 = DEADBEEF, words 0..7 otherwise 11111111*(i+1).
    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        if (i == 4)      v = 32'hDEADBEEF;
        else if (i < 8)  v = 32'h11111111 * 32'(i + 1);
        else             v = 32'(i);
        return v;
    endfunction

    // ---------------- BRAM environment model (read-first, latency 2) ----------
    logic [31:0] mem    [16384];
    bit          mem_wr [16384];
    logic [31:0] q1 = 32'h0;
    logic [31:0] q2 = 32'h0;

    function automatic logic [31:0] env_word(input logic [13:0] idx);
        return mem_wr[idx] ? mem[idx] : init_word(int'(idx));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign bram_rddata_i = q2;

    always @(posedge clk) begin
        if (bram_rst_o) begin
            q1 <= 32'h0;
            q2 <= 32'h0;
        end else begin
            q2 <= q1;
            if (bram_en_o) begin
                q1 <= env_word(bram_addr_o[AW-1:2]);
                if (bram_we_o != 4'h0) begin
                    mem[bram_addr_o[AW-1:2]]    <= merge(env_word(bram_addr_o[AW-1:2]),
                                                         bram_wrdata_o, bram_we_o);
                    mem_wr[bram_addr_o[AW-1:2]] <= 1'b1;
                end
            end
        end
    end

    // ---------------- reference model ----------------------------------------
    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    int          errdue[$];
    logic [7:0]  sh    [65536];
    bit          sh_wr [65536];
    int          cyc   = 0;
    int          m_rd  = 0;
    int          m_wr  = 0;
    int          m_err = 0;

    function automatic logic [7:0] sh_byte(input int a);
        logic [31:0] w;
        w = init_word(a / 4);
        return sh_wr[a] ? sh[a] : w[8*(a%4) +: 8];
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            rq.delete();
            errdue.delete();
            m_rd  <= 0;
            m_wr  <= 0;
            m_err <= 0;
        end else begin
            // err_count follows the error response by one cycle
            if (errdue.size() > 0 && errdue[0] == cyc) begin
                void'(errdue.pop_front());
                m_err <= sat(m_err);
            end
            if (req_i) begin
                resp_t r;
                int    a;
                bit    inr;
                inr    = ((addr_i >> AW) == (BASE >> AW));
                a      = int'(addr_i % 65536) / 4 * 4;
                r.due  = cyc + L;
                r.err  = !inr;
                r.data = 32'h0;
                if (inr && !we_i)
                    r.data = {sh_byte(a+3), sh_byte(a+2), sh_byte(a+1), sh_byte(a)};
                if (inr && we_i) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) begin
                            sh[a+b]    <= wdata_i[8*b +: 8];
                            sh_wr[a+b] <= 1'b1;
                        end
                end
                if (inr && !we_i) m_rd <= sat(m_rd);
                if (inr && we_i)  m_wr <= sat(m_wr);
                if (!inr) errdue.push_back(cyc + L);
                rq.push_back(r);
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_n) begin
                check("rst:gnt_o", gnt_o, 0);
                check("rst:bram_en_o", bram_en_o, 0);
                check("rst:bram_we_o", bram_we_o, 0);
                check("rst:bram_rst_o", bram_rst_o, 1);
                check("rst:rvalid_o", rvalid_o, 0);
                check("rst:err_o", err_o, 0);
                check("rst:rdata_o", rdata_o, 0);
                check("rst:rd_count_o", rd_count_o, 0);
                check("rst:wr_count_o", wr_count_o, 0);
                check("rst:err_count_o", err_count_o, 0);
            end else begin
                bit inr;
                bit en;
                inr = ((addr_i >> AW) == (BASE >> AW));
                en  = req_i && inr;
                check("gnt_o", gnt_o, req_i);
                check("bram_en_o", bram_en_o, en);
                check("bram_we_o", bram_we_o, (en && we_i) ? be_i : 4'h0);
                check("bram_rst_o", bram_rst_o, 0);
                if (en) begin
                    check("bram_addr_o", bram_addr_o, addr_i & 32'h0000FFFC);
                    check("bram_wrdata_o", bram_wrdata_o, wdata_i);
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    check("rvalid_o", rvalid_o, 1);
                    check("err_o", err_o, rq[0].err);
                    check("rdata_o", rdata_o, rq[0].data);
                    void'(rq.pop_front());
                end else begin
                    check("idle:rvalid_o", rvalid_o, 0);
                    check("idle:err_o", err_o, 0);
                    check("idle:rdata_o", rdata_o, 0);
                end
                check("rd_count_o", rd_count_o, 32'(m_rd));
                check("wr_count_o", wr_count_o, 32'(m_wr));
                check("err_count_o", err_count_o, 32'(m_err));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ------------
    task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_stream [8];
        exp_stream = '{32'h11111111, 32'h22222222, 32'h3333AB33, 32'h44444444,
                       32'hDEADBEEF, 32'h66666666, 32'h77777777, 32'h88888888};

        // Reset held with a request pending: nothing may be granted
        set_req(1, 0, 32'h10, 4'hF, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk);
        check("lit:rst gnt_o", gnt_o, 0);
        check("lit:rst bram_en_o", bram_en_o, 0);
        check("lit:rst bram_rst_o", bram_rst_o, 1);
        check("lit:rst rvalid_o", rvalid_o, 0);

        // First cycle out of reset: read 0x10 granted immediately
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("lit:rd gnt_o", gnt_o, 1);
        check("lit:rd bram_en_o", bram_en_o, 1);
        check("lit:rd bram_addr_o", bram_addr_o, 32'h10);
        next_cycle();
        set_req(0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("lit:rd t+1 rvalid_o", rvalid_o, 0);
        check("lit:rd rd_count_o", rd_count_o, 1);
        next_cycle();
        @(negedge clk);
        check("lit:rd t+2 rvalid_o", rvalid_o, 1);
        check("lit:rd t+2 rdata_o", rdata_o, 32'hDEADBEEF);
        check("lit:rd t+2 err_o", err_o, 0);
        next_cycle();

        // Byte write to 0x8, then read it back the very next cycle
        set_req(1, 1, 32'h8, 4'b0010, 32'h0000AB00);
        @(negedge clk);
        check("lit:wr bram_we_o", bram_we_o, 4'b0010);
        check("lit:wr bram_en_o", bram_en_o, 1);
        next_cycle();
        set_req(1, 0, 32'h8, 4'hF, 32'hFFFFFFFF);
        next_cycle();
        set_req(0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("lit:wr resp rvalid_o", rvalid_o, 1);
        check("lit:wr resp rdata_o", rdata_o, 32'h0);
        next_cycle();
        @(negedge clk);
        check("lit:raw rvalid_o", rvalid_o, 1);
        check("lit:raw rdata_o", rdata_o, 32'h3333AB33);
        check("lit:wr wr_count_o", wr_count_o, 1);
        next_cycle();

        // Eight back-to-back reads of 0x0..0x1C
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_req(1, 0, 32'(i * 4), 4'hF, 32'h0);
            else       set_req(0, 0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("lit:stream%0d rvalid_o", i - 2), rvalid_o, 1);
                check($sformatf("lit:stream%0d rdata_o", i - 2), rdata_o, exp_stream[i-2]);
            end
            next_cycle();
        end

        // Out-of-range read
        set_req(1, 0, 32'h0001_0000, 4'hF, 32'h0);
        @(negedge clk);
        check("lit:oor gnt_o", gnt_o, 1);
        check("lit:oor bram_en_o", bram_en_o, 0);
        next_cycle();
        set_req(0, 0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        check("lit:oor rvalid_o", rvalid_o, 1);
        check("lit:oor err_o", err_o, 1);
        check("lit:oor rdata_o", rdata_o, 32'h0);
        next_cycle();
        @(negedge clk);
        check("lit:oor err_count_o", err_count_o, 1);
        next_cycle();

        // Reset with two reads in flight: they must vanish
        set_req(1, 0, 32'h0, 4'hF, 32'h0);
        next_cycle();
        set_req(1, 0, 32'h4, 4'hF, 32'h0);
        next_cycle();
        set_req(0, 0, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("lit:midrst bram_rst_o", bram_rst_o, 1);
        check("lit:midrst rvalid_o", rvalid_o, 0);
        check("lit:midrst rd_count_o", rd_count_o, 0);
        check("lit:midrst err_count_o", err_count_o, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("lit:postrst%0d rvalid_o", i), rvalid_o, 0);
            next_cycle();
        end

        // Saturation: 65537 read grants leave rd_count at FFFF
        set_req(1, 0, 32'h10, 4'hF, 32'h0);
        repeat (65537) next_cycle();
        set_req(0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("lit:sat rd_count_o", rd_count_o, 32'h0000FFFF);
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
